// File: rtl/dtree_pkg.sv
// Shared types and default widths for the sequential decision-tree controller.
// The node record matches the port bundle driven by an external node table.
package dtree_pkg;

  localparam int DEF_N_FEAT    = 16;
  localparam int DEF_FEAT_W    = 8;
  localparam int DEF_CLASS_W   = 4;
  localparam int DEF_NODE_W    = 6;
  localparam int DEF_MAX_DEPTH = 8;
  localparam int DEF_FI_W      = $clog2(DEF_N_FEAT);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                   leaf;
    logic [DEF_FI_W-1:0]    feat;
    logic [DEF_FEAT_W-1:0]  thr;
    logic [DEF_NODE_W-1:0]  left;
    logic [DEF_NODE_W-1:0]  right;
    logic [DEF_CLASS_W-1:0] cls;
  } node_t;

endpackage

// File: rtl/dtree_feat_rf.sv
// Feature register file: one write port fed by the load stream, one
// combinational read port indexed by the current node's feature field.
module dtree_feat_rf
  import dtree_pkg::*;
#(
  parameter int N_FEAT = DEF_N_FEAT,
  parameter int FEAT_W = DEF_FEAT_W,
  localparam int FI_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [FI_W-1:0]   waddr,
  input  logic [FEAT_W-1:0] wdata,
  input  logic [FI_W-1:0]   raddr,
  output logic [FEAT_W-1:0] rdata
);

  logic [FEAT_W-1:0] mem_r [N_FEAT];
  logic [FEAT_W-1:0] rdata_s;

  // Storage: synchronous clear of every entry, otherwise write the addressed entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_FEAT; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < N_FEAT; i++) begin
        if (waddr == FI_W'(i)) begin
          mem_r[i] <= wdata;
        end
      end
    end
  end

  // Read mux as an AND-OR tree; an index with no matching entry reads as zero.
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      rdata_s = rdata_s | (mem_r[i] & {FEAT_W{raddr == FI_W'(i)}});
    end
  end

  assign rdata = rdata_s;

endmodule

// File: rtl/dtree_seq_ctrl.sv
// Sequential decision-tree evaluator: serial feature load, one node visit per
// cycle through a shared comparator, result returned on a valid/ready port.
module dtree_seq_ctrl
  import dtree_pkg::*;
#(
  parameter int N_FEAT    = DEF_N_FEAT,
  parameter int FEAT_W    = DEF_FEAT_W,
  parameter int CLASS_W   = DEF_CLASS_W,
  parameter int NODE_W    = DEF_NODE_W,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  localparam int FI_W     = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FEAT_W-1:0]  in_data,
  output logic [NODE_W-1:0]  node_addr,
  input  logic               nd_leaf,
  input  logic [FI_W-1:0]    nd_feat,
  input  logic [FEAT_W-1:0]  nd_thr,
  input  logic [NODE_W-1:0]  nd_left,
  input  logic [NODE_W-1:0]  nd_right,
  input  logic [CLASS_W-1:0] nd_class,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic               out_err,
  output logic               busy
);

  localparam int DEPTH_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(MAX_DEPTH - 1);
  localparam logic [FI_W-1:0]    BEAT_LAST  = FI_W'(N_FEAT - 1);

  state_t               state_r;
  logic [FI_W-1:0]      count_r;
  logic [NODE_W-1:0]    node_addr_r;
  logic [DEPTH_W-1:0]   depth_r;
  logic [CLASS_W-1:0]   out_class_r;
  logic                 out_err_r;

  logic                 feat_we_s;
  logic [FEAT_W-1:0]    feat_rd_s;
  logic                 bad_feat_s;
  logic                 take_left_s;

  assign feat_we_s   = (state_r == ST_LOAD) && in_valid;
  // Widened so the range test stays meaningful when N_FEAT is not a power of two.
  assign bad_feat_s  = (32'(nd_feat) >= 32'(N_FEAT));
  assign take_left_s = (feat_rd_s <= nd_thr);

  dtree_feat_rf #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W)
  ) u_feat_rf (
    .clk   (clk),
    .clr   (rst),
    .we    (feat_we_s),
    .waddr (count_r),
    .wdata (in_data),
    .raddr (nd_feat),
    .rdata (feat_rd_s)
  );

  // Controller FSM: beat counting, tree walk with depth guard, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_LOAD;
      count_r     <= '0;
      node_addr_r <= '0;
      depth_r     <= '0;
      out_class_r <= '0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (in_valid) begin
            if (count_r == BEAT_LAST) begin
              count_r     <= '0;
              node_addr_r <= '0;
              depth_r     <= '0;
              state_r     <= ST_EVAL;
            end else begin
              count_r <= count_r + FI_W'(1);
            end
          end
        end
        ST_EVAL: begin
          if (nd_leaf) begin
            out_class_r <= nd_class;
            out_err_r   <= 1'b0;
            state_r     <= ST_DONE;
          end else if (bad_feat_s || (depth_r == DEPTH_LAST)) begin
            out_class_r <= '0;
            out_err_r   <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            node_addr_r <= take_left_s ? nd_left : nd_right;
            depth_r     <= depth_r + DEPTH_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_LOAD;
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_LOAD);
  assign busy      = (state_r != ST_LOAD);
  assign out_valid = (state_r == ST_DONE);
  assign node_addr = node_addr_r;
  assign out_class = out_class_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Self-checking bench for dtree_seq_ctrl: directed scenarios plus randomized
// trees and vectors compared every cycle against a tree-walk reference model.
module tb_dtree_seq_ctrl;
  import dtree_pkg::*;

  localparam int MAXD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic [5:0] node_addr;
  logic       nd_leaf;
  logic [3:0] nd_feat;
  logic [7:0] nd_thr;
  logic [5:0] nd_left;
  logic [5:0] nd_right;
  logic [3:0] nd_class;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_class;
  logic       out_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  node_t      tbl [64];
  logic [7:0] vec [16];

  always #5 clk = ~clk;

  assign nd_leaf  = tbl[node_addr].leaf;
  assign nd_feat  = tbl[node_addr].feat;
  assign nd_thr   = tbl[node_addr].thr;
  assign nd_left  = tbl[node_addr].left;
  assign nd_right = tbl[node_addr].right;
  assign nd_class = tbl[node_addr].cls;

  dtree_seq_ctrl #(
    .N_FEAT(16), .FEAT_W(8), .CLASS_W(4), .NODE_W(6), .MAX_DEPTH(MAXD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .node_addr(node_addr),
    .nd_leaf(nd_leaf), .nd_feat(nd_feat), .nd_thr(nd_thr),
    .nd_left(nd_left), .nd_right(nd_right), .nd_class(nd_class),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err), .busy(busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction phases plus a plain tree walk.
  typedef enum {M_LOAD, M_EVAL, M_RES} mphase_t;
  mphase_t    m_phase = M_LOAD;
  logic [7:0] m_feat [16];
  int         m_beats = 0;
  int         m_path [$];
  int         m_idx = 0;
  int         m_class = 0;
  int         m_err = 0;
  bit         chk_en = 1'b0;

  task automatic model_walk();
    int addr;
    addr = 0;
    m_path.delete();
    for (int s = 0; s < MAXD; s++) begin
      m_path.push_back(addr);
      if (tbl[addr].leaf) begin
        m_class = int'(tbl[addr].cls); m_err = 0; return;
      end
      if (int'(tbl[addr].feat) >= 16 || s == MAXD - 1) begin
        m_class = 0; m_err = 1; return;
      end
      addr = (m_feat[tbl[addr].feat] <= tbl[addr].thr) ? int'(tbl[addr].left) : int'(tbl[addr].right);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_LOAD;
      m_beats = 0;
    end else begin
      case (m_phase)
        M_LOAD: if (in_valid) begin
          m_feat[m_beats] = in_data;
          m_beats++;
          if (m_beats == 16) begin
            model_walk();
            m_beats = 0;
            m_idx   = 0;
            m_phase = M_EVAL;
          end
        end
        M_EVAL: begin
          m_idx++;
          if (m_idx == m_path.size()) m_phase = M_RES;
        end
        default: if (out_ready) m_phase = M_LOAD;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_phase == M_LOAD);
      check("busy", busy, m_phase != M_LOAD);
      check("out_valid", out_valid, m_phase == M_RES);
      if (m_phase == M_EVAL) check("node_addr", node_addr, m_path[m_idx]);
      if (m_phase == M_RES) begin
        check("out_class", out_class, m_class);
        check("out_err", out_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic set_node(input int i, input bit leaf, input int f, input int thr,
                          input int l, input int r, input int c);
    tbl[i].leaf  = leaf;
    tbl[i].feat  = 4'(f);
    tbl[i].thr   = 8'(thr);
    tbl[i].left  = 6'(l);
    tbl[i].right = 6'(r);
    tbl[i].cls   = 4'(c);
  endtask

  task automatic table_a();
    for (int i = 0; i < 64; i++) set_node(i, 1'b1, 0, 0, 0, 0, 0);
    set_node(0, 1'b0, 15, 127, 1, 2, 0);
    set_node(1, 1'b1, 0, 0, 0, 0, 7);
    set_node(2, 1'b0, 3, 63, 3, 4, 0);
    set_node(3, 1'b1, 0, 0, 0, 0, 2);
    set_node(4, 1'b1, 0, 0, 0, 0, 9);
  endtask

  task automatic table_rand();
    for (int i = 0; i < 64; i++)
      set_node(i, (i >= 40) || ($urandom_range(0, 2) == 0), $urandom_range(0, 15),
               $urandom_range(0, 255), $urandom_range(0, 63), $urandom_range(0, 63),
               $urandom_range(0, 15));
    tbl[0].leaf = 1'b0;
  endtask

  task automatic set_vec(input int f15, input int f3);
    for (int k = 0; k < 16; k++) vec[k] = 8'd0;
    vec[15] = 8'(f15);
    vec[3]  = 8'(f3);
  endtask

  // Streams vec[0..15]; returns in cycle t+1 after the last accepted beat.
  task automatic load_vec(input bit gaps);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    if (!in_ready) begin
      check("load_ready_timeout", 0, 1);
      do_reset(2);
    end
    for (int k = 0; k < 16; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_data = 8'($urandom); tick();
        end
      end
      in_valid = 1'b1; in_data = vec[k]; tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, input bit junk);
    int guard;
    guard = 0;
    while (!out_valid && guard < 40) begin tick(); guard++; end
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      do_reset(2);
      return;
    end
    repeat (hold) begin
      if (junk) begin in_valid = 1'b1; in_data = 8'($urandom); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    table_a();
    // 1: reset
    do_reset(2);
    chk_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    check("rst_node_addr", node_addr, 0);
    tick();
    check("rst_in_ready", in_ready, 1);

    // 2: path 0 -> 2 -> 4, class 9
    set_vec(8'h80, 8'h40);
    load_vec(1'b0);
    check("model_s2", m_class, 9);
    check("s2_addr_t1", node_addr, 0); tick();
    check("s2_addr_t2", node_addr, 2); tick();
    check("s2_addr_t3", node_addr, 4); check("s2_valid_t3", out_valid, 0); tick();
    check("s2_valid_t4", out_valid, 1);
    check("s2_class", out_class, 9);
    check("s2_err", out_err, 0);
    wait_result(0, 1'b0);

    // 3: threshold boundaries
    set_vec(8'h7F, 8'h00);
    load_vec(1'b0);
    check("s3a_addr_t1", node_addr, 0); tick();
    check("s3a_addr_t2", node_addr, 1); tick();
    check("s3a_valid_t3", out_valid, 1);
    check("s3a_class", out_class, 7);
    wait_result(0, 1'b0);
    set_vec(8'h80, 8'h3F);
    load_vec(1'b0);
    repeat (3) tick();
    check("s3b_class", out_class, 2);
    wait_result(0, 1'b0);

    // 4: backpressure with in_valid junk during DONE
    set_vec(8'h80, 8'h40);
    load_vec(1'b0);
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hFF;
      check("s4_valid_hold", out_valid, 1);
      check("s4_class_hold", out_class, 9);
      check("s4_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s4_in_ready_after", in_ready, 1);
    set_vec(8'h7F, 8'h00);
    load_vec(1'b0);
    check("model_s4", m_class, 7);
    wait_result(1, 1'b0);

    // 5: self-loop table aborts after MAXD eval cycles
    set_node(0, 1'b0, 0, 0, 0, 0, 0);
    set_vec(8'h11, 8'h22);
    load_vec(1'b0);
    for (int i = 0; i < MAXD; i++) begin
      check("s5_busy", busy, 1);
      check("s5_no_valid", out_valid, 0);
      tick();
    end
    check("s5_valid", out_valid, 1);
    check("s5_err", out_err, 1);
    check("s5_class", out_class, 0);
    wait_result(0, 1'b0);

    // 6: reset mid-EVAL and mid-LOAD, then a clean load
    table_a();
    set_vec(8'h80, 8'h40);
    load_vec(1'b0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("s6_out_valid", out_valid, 0);
    check("s6_busy", busy, 0);
    check("s6_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin in_valid = 1'b1; in_data = 8'hAA; tick(); end
    do_reset(1);
    set_vec(8'h80, 8'h3F);
    load_vec(1'b0);
    repeat (3) tick();
    check("s6_valid", out_valid, 1);
    check("s6_class", out_class, 2);
    wait_result(0, 1'b0);

    // 7: randomized trees, vectors, gaps, backpressure and resets
    for (int it = 0; it < 40; it++) begin
      table_rand();
      for (int k = 0; k < 16; k++) vec[k] = 8'($urandom);
      load_vec(1'b1);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 5)) tick();
        rst = 1'b1; tick(); rst = 1'b0;
      end else begin
        wait_result($urandom_range(0, 3), 1'b1);
      end
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
